// File: rtl/seq_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_acc_pkg
//  Purpose  : Shared types, constants and arithmetic helpers for the
//             seq_result_accumulator slice.
//  Contents : acc_state_e  - accumulator FSM states (IDLE, ACCUM)
//             ACC_MAX/MIN  - saturation limits for the default 32-bit width
//             add_ovf()    - signed overflow detect from operand/sum sign bits
//             sat_add()    - width-generic saturating add (widths up to 64)
//  Revision : 1.0  initial release
// ============================================================================
package seq_acc_pkg;

    // Widest accumulator the width-generic helpers support.
    localparam int ACC_WIDTH_MAX = 64;
    typedef logic [ACC_WIDTH_MAX-1:0] acc_wide_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    localparam int ACC_WIDTH_DEF = 32;
    localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
    localparam logic [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

    // Same-sign operands producing a sum of the opposite sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Adds the low 'width' bits of a and b as signed numbers and clamps to the
    // representable range on overflow. Result is returned in the low 'width'
    // bits; upper bits are zero.
    function automatic acc_wide_t sat_add(input acc_wide_t a, input acc_wide_t b, input int width);
        acc_wide_t mask;
        acc_wide_t sum;
        acc_wide_t max_v;
        acc_wide_t min_v;
        logic      a_msb;
        logic      b_msb;
        logic      s_msb;
        mask  = (width >= ACC_WIDTH_MAX) ? '1 : ((acc_wide_t'(1) << width) - acc_wide_t'(1));
        sum   = (a + b) & mask;
        max_v = mask >> 1;
        min_v = mask & ~max_v;
        a_msb = |(a & min_v);
        b_msb = |(b & min_v);
        s_msb = |(sum & min_v);
        if (add_ovf(a_msb, b_msb, s_msb)) begin
            sum = a_msb ? min_v : max_v;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_acc_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : seq_acc_fifo
//  Purpose  : DEPTH x WIDTH first-word-fall-through FIFO holding finished sums.
//             Head word is visible on o_data whenever o_empty is low; o_data
//             reads zero while empty. Pointers wrap explicitly so DEPTH need
//             not be a power of two.
//  Ports    : clk, rst_n (async, active-low)
//             i_clear  - synchronous flush, wins over push and pop
//             i_push / i_data - write request (ignored when full)
//             i_pop    - read request (ignored when empty)
//             o_data, o_full, o_empty
//  Revision : 1.0  initial release
// ============================================================================
module seq_acc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_en;
    logic               w_pop_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_push_en = i_push && !o_full && !i_clear;
    assign w_pop_en  = i_pop && !o_empty && !i_clear;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked by o_empty.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_result_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_result_accumulator
//  Purpose  : Sums groups of tile_count consecutive signed results from
//             seq_mult_adder into one signed value and queues finished sums
//             in a small first-word-fall-through FIFO.
//  Ports    : clk_i, rst_ni (async, active-low)
//             d_in/valid_in/ready_in    - incoming partial results
//             tile_count                - group size, sampled on first beat
//                                         (0 is treated as 1)
//             clear                     - synchronous flush of everything
//             result/valid_out/ready_out- outgoing sums (FIFO head)
//             busy                      - a group is partially accumulated
//             overflow                  - sticky signed-overflow flag
//  Config   : SEQ_RESULT_ACC_SATURATE_EN - when defined, overflowing sums
//             clamp to the signed range instead of wrapping. ACC_WIDTH must
//             not exceed 64 in that mode.
//  Revision : 1.0  initial release
// ============================================================================
module seq_result_accumulator
    import seq_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ACC_WIDTH-1:0] d_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [CNT_WIDTH-1:0] tile_count,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 busy,
    output logic                 overflow
);

    acc_state_e           r_state;
    acc_state_e           w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_n;
    logic [CNT_WIDTH-1:0] w_n_nxt;
    logic [CNT_WIDTH-1:0] w_n_first;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 w_ovf_set;

    logic [ACC_WIDTH-1:0] w_sum_wrap;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_sum_ovf;

    logic                 w_accept;
    logic                 w_push;
    logic [ACC_WIDTH-1:0] w_push_data;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // ready_in depends only on registered FIFO occupancy, never on ready_out.
    assign ready_in  = !w_fifo_full;
    assign valid_out = !w_fifo_empty;
    assign w_accept  = valid_in && ready_in;
    assign w_pop     = valid_out && ready_out;
    assign busy      = (r_state == ACCUM);
    assign overflow  = r_ovf;

    assign w_n_first  = (tile_count == '0) ? CNT_WIDTH'(1) : tile_count;
    assign w_cnt_inc  = r_cnt + CNT_WIDTH'(1);
    assign w_sum_wrap = r_acc + d_in;
    assign w_sum_ovf  = add_ovf(r_acc[ACC_WIDTH-1], d_in[ACC_WIDTH-1], w_sum_wrap[ACC_WIDTH-1]);

`ifdef SEQ_RESULT_ACC_SATURATE_EN
    acc_wide_t w_sum_wide;
    assign w_sum_wide = sat_add(acc_wide_t'(r_acc), acc_wide_t'(d_in), ACC_WIDTH);
    assign w_sum      = w_sum_wide[ACC_WIDTH-1:0];
`else
    assign w_sum      = w_sum_wrap;
`endif

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_push      = 1'b0;
        w_push_data = d_in;
        w_ovf_set   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_n_nxt = w_n_first;
                    if (w_n_first == CNT_WIDTH'(1)) begin
                        // Single-beat group: passes straight through, no add.
                        w_push = 1'b1;
                    end else begin
                        w_acc_nxt   = d_in;
                        w_cnt_nxt   = CNT_WIDTH'(1);
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_ovf_set = w_sum_ovf;
                    if (w_cnt_inc == r_n) begin
                        w_push      = 1'b1;
                        w_push_data = w_sum;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // clear discards everything, including a beat accepted this cycle.
        if (clear) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_push      = 1'b0;
            w_ovf_set   = 1'b0;
        end

        w_ovf_nxt = clear ? 1'b0 : (r_ovf | w_ovf_set);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n     <= CNT_WIDTH'(1);
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    seq_acc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ACC_WIDTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .i_clear (clear),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (result),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_result_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_result_accumulator
//  Purpose  : Self-checking bench for seq_result_accumulator (32-bit, DEPTH 4).
//             Directed scenarios followed by a randomized run, all checked
//             against an arithmetic reference model of group sums and a
//             queue of pending results.
//  Config   : honours SEQ_RESULT_ACC_SATURATE_EN for expected sums.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_result_accumulator;

    localparam int     DEPTH = 4;
    localparam longint MAXV  = 64'sd2147483647;
    localparam longint MINV  = -MAXV - 64'sd1;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_in;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  tile_count;
    logic        clear;
    logic [31:0] result;
    logic        valid_out;
    logic        ready_out;
    logic        busy;
    logic        overflow;

    seq_result_accumulator #(
        .ACC_WIDTH (32),
        .CNT_WIDTH (8),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .tile_count (tile_count),
        .clear      (clear),
        .result     (result),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] q[$];        // finished sums awaiting pop
    logic [31:0] popped[$];   // values observed leaving the DUT
    longint      m_sum;
    int          m_left;      // beats still needed to finish the current group
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint fold(input longint a, input longint b, output bit ovf);
        longint s;
        s   = a + b;
        ovf = (s > MAXV) || (s < MINV);
`ifdef SEQ_RESULT_ACC_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`else
        if (s > MAXV) s = s - 64'sd4294967296;
        if (s < MINV) s = s + 64'sd4294967296;
`endif
        return s;
    endfunction

    task automatic model_clear();
        q.delete();
        m_sum  = 0;
        m_left = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [7:0] tc);
        longint dv;
        int     n;
        bit     ov;
        dv = longint'($signed(d));
        if (m_left == 0) begin
            n = (tc == 8'd0) ? 1 : int'(tc);
            if (n == 1) begin
                q.push_back(d);
            end else begin
                m_sum  = dv;
                m_left = n - 1;
            end
        end else begin
            m_sum = fold(m_sum, dv, ov);
            if (ov) m_ovf = 1'b1;
            m_left--;
            if (m_left == 0) q.push_back(32'(m_sum));
        end
    endtask

    task automatic check_outputs();
        check("valid_out", 32'(valid_out), 32'(q.size() != 0));
        check("ready_in", 32'(ready_in), 32'(q.size() < DEPTH));
        check("busy", 32'(busy), 32'(m_left != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("result", result, (q.size() != 0) ? q[0] : 32'd0);
    endtask

    // One clock cycle: drive inputs, advance the model on the observed
    // handshakes, then compare every output against the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] tc,
                         input logic rdy, input logic clr, output logic accepted);
        logic pop_now;
        logic acc_now;
        valid_in   = v;
        d_in       = d;
        tile_count = tc;
        ready_out  = rdy;
        clear      = clr;
        #1;
        acc_now  = v && ready_in;
        pop_now  = valid_out && rdy;
        if (pop_now && !clr) popped.push_back(result);
        @(posedge clk);
        #1;
        if (clr) begin
            model_clear();
        end else begin
            if (pop_now && q.size() != 0) void'(q.pop_front());
            if (acc_now) model_beat(d, tc);
        end
        check_outputs();
        accepted = acc_now && !clr;
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic drain();
        logic a;
        int   k;
        k = 0;
        while (valid_out && k < 20) begin
            cycle(1'b0, 32'd0, 8'd1, 1'b1, 1'b0, a);
            k++;
        end
        check("drain_done", 32'(valid_out), 32'd0);
    endtask

    initial begin
        logic        a;
        logic [31:0] d;
        logic [31:0] exp_ovf_sum;
        int          tries;

        rst_n = 1'b0; valid_in = 1'b0; d_in = '0; tile_count = '0;
        ready_out = 1'b0; clear = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Single-beat group passes through with one cycle of latency.
        cycle(1'b1, 32'hFFFF_FFFA, 8'd1, 1'b0, 1'b0, a);
        check("t1_result", result, 32'hFFFF_FFFA);
        check("t1_valid", 32'(valid_out), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        drain();

        // Three-beat group.
        cycle(1'b1, 32'd100, 8'd3, 1'b0, 1'b0, a);
        check("t2_busy1", 32'(busy), 32'd1);
        cycle(1'b1, -32'sd30, 8'd3, 1'b0, 1'b0, a);
        check("t2_busy2", 32'(busy), 32'd1);
        check("t2_no_result_yet", 32'(valid_out), 32'd0);
        cycle(1'b1, 32'd7, 8'd3, 1'b0, 1'b0, a);
        check("t2_busy3", 32'(busy), 32'd0);
        check("t2_result", result, 32'd77);
        drain();

        // Fill the FIFO while stalled, then drain in order.
        popped.delete();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 8'd1, 1'b0, 1'b0, a);
        check("t3_ready_full", 32'(ready_in), 32'd0);
        tries = 0;
        a = 1'b0;
        while (!a && tries < 10) begin
            cycle(1'b1, 32'd5, 8'd1, 1'b1, 1'b0, a);
            tries++;
        end
        check("t3_fifth_accepted", 32'(a), 32'd1);
        drain();
        check("t3_pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            d = (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
            check("t3_pop_order", d, 32'(i + 1));
        end

        // Positive overflow.
`ifdef SEQ_RESULT_ACC_SATURATE_EN
        exp_ovf_sum = 32'h7FFF_FFFF;
`else
        exp_ovf_sum = 32'h8000_0000;
`endif
        cycle(1'b1, 32'h7FFF_FFFF, 8'd2, 1'b0, 1'b0, a);
        cycle(1'b1, 32'd1, 8'd2, 1'b0, 1'b0, a);
        check("t4_result", result, exp_ovf_sum);
        check("t4_overflow", 32'(overflow), 32'd1);
        drain();

        // Clear mid-group.
        cycle(1'b1, 32'd10, 8'd4, 1'b0, 1'b0, a);
        cycle(1'b1, 32'd20, 8'd4, 1'b0, 1'b0, a);
        cycle(1'b1, 32'd30, 8'd4, 1'b0, 1'b1, a);
        check("t5_cleared_busy", 32'(busy), 32'd0);
        check("t5_cleared_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 32'd3, 8'd2, 1'b0, 1'b0, a);
        cycle(1'b1, 32'd4, 8'd2, 1'b0, 1'b0, a);
        check("t5_result", result, 32'd7);
        check("t5_overflow", 32'(overflow), 32'd0);
        drain();

        // Asynchronous reset mid-group with a result queued.
        cycle(1'b1, 32'd11, 8'd1, 1'b0, 1'b0, a);
        cycle(1'b1, 32'd5, 8'd3, 1'b0, 1'b0, a);
        rst_n = 1'b0;
        #1;
        check("t6_valid_now", 32'(valid_out), 32'd0);
        check("t6_busy_now", 32'(busy), 32'd0);
        check("t6_result_now", result, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 32'd9, 8'd0, 1'b0, 1'b0, a);
        check("t6_zero_count", result, 32'd9);
        check("t6_zero_busy", 32'(busy), 32'd0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 32'($urandom_range(0, 200)) - 32'd100;
                1:       d = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
                2:       d = 32'h8000_0000 + 32'($urandom_range(0, 15));
                default: d = $urandom();
            endcase
            cycle(1'($urandom_range(0, 3) != 0), d, 8'($urandom_range(0, 4)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0), a);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
